// File: rtl/wasca_leds.sv
// Avalon-MM output PIO for board LEDs: data register with atomic set/clear and
// per-bit hardware blink timed by a reloadable half-period down-counter.
module wasca_leds #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      DIV_WIDTH   = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] AddrData     = 3'd0;
   localparam logic [2:0] AddrBlinkEn  = 3'd1;
   localparam logic [2:0] AddrBlinkDiv = 3'd2;
   localparam logic [2:0] AddrStatus   = 3'd3;
   localparam logic [2:0] AddrOutSet   = 3'd4;
   localparam logic [2:0] AddrOutClr   = 3'd5;

   logic [WIDTH-1:0]     data_q, data_d;
   logic [WIDTH-1:0]     blink_en_q, blink_en_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 phase_q, phase_d;
   logic [31:0]          readdata_q, readdata_d;
   logic [WIDTH-1:0]     out_q, out_d;

   logic                 wr_en;
   logic                 div_wr;
   logic [WIDTH-1:0]     wdata;

   assign wr_en = chipselect && !write_n;
   assign wdata = writedata[WIDTH-1:0];

   always_comb begin
      data_d     = data_q;
      blink_en_d = blink_en_q;
      div_d      = div_q;
      div_wr     = 1'b0;
      if (wr_en) begin
         case (address)
            AddrData:     data_d     = wdata;
            AddrBlinkEn:  blink_en_d = wdata;
            AddrBlinkDiv: begin
               div_d  = writedata[DIV_WIDTH-1:0];
               div_wr = 1'b1;
            end
            AddrOutSet:   data_d     = data_q | wdata;
            AddrOutClr:   data_d     = data_q & ~wdata;
            default:      ;
         endcase
      end
   end

   // Reloading on cnt==1 as well as 0 gives a toggle every N cycles for BLINK_DIV=N.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (div_wr) begin
         cnt_d   = div_d;
         phase_d = 1'b0;
      end else if (div_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if ((cnt_q == '0) || (cnt_q == DIV_WIDTH'(1))) begin
         cnt_d   = div_q;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q - DIV_WIDTH'(1);
      end
   end

   always_comb begin
      out_d      = data_d & ~(blink_en_d & {WIDTH{phase_d}});
      readdata_d = '0;
      case (address)
         AddrData:     readdata_d[WIDTH-1:0]     = data_q;
         AddrBlinkEn:  readdata_d[WIDTH-1:0]     = blink_en_q;
         AddrBlinkDiv: readdata_d[DIV_WIDTH-1:0] = div_q;
         AddrStatus:   readdata_d[0]             = phase_q;
         default:      ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         blink_en_q <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         readdata_q <= '0;
         out_q      <= RESET_VALUE;
      end else begin
         data_q     <= data_d;
         blink_en_q <= blink_en_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
         out_q      <= out_d;
      end
   end

   assign readdata = readdata_q;
   assign out_port = out_q;

endmodule

// File: tb/tb_wasca_leds.sv
// Bench for wasca_leds: directed bus traffic pushes timed expectations into a
// scoreboard; a negedge monitor checks out_port/readdata when each falls due.
module tb_wasca_leds;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   wasca_leds #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5),
      .DIV_WIDTH   (24)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          sig;   // 0: out_port, 1: readdata
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;

   always @(negedge clk) begin
      exp_t        keep[$];
      logic [31:0] act;
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].due == cyc) begin
            act = (sb[i].sig == 0) ? {24'd0, out_port} : readdata;
            n_checks++;
            if (act === sb[i].val) n_pass++;
            else $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].val);
         end else if (sb[i].due < cyc) begin
            n_checks++;
            $display("FAIL %s: never sampled (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input int delay, input int sig, input logic [31:0] val,
                           input string name);
      exp_t e;
      e.due  = cyc + delay;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic bus_wr(input logic cs, input logic [2:0] a, input logic [31:0] d);
      chipselect = cs;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic read_chk(input logic [2:0] a, input logic [31:0] val, input string name);
      address = a;
      tick();
      expect_v(0, 1, val, name);
   endtask

   initial begin
      // Reset state
      tick();
      expect_v(0, 0, 32'hA5, "rst_out");
      expect_v(0, 1, 32'h0, "rst_rd");
      tick();
      reset_n = 1'b1;
      read_chk(3'd0, 32'hA5, "rd_data_after_rst");

      // Data write, set, clear
      bus_wr(1'b1, 3'd0, 32'hFFFF_FF0F);
      expect_v(0, 0, 32'h0F, "wr_data");
      bus_wr(1'b1, 3'd4, 32'h30);
      expect_v(0, 0, 32'h3F, "outset");
      bus_wr(1'b1, 3'd5, 32'h05);
      expect_v(0, 0, 32'h3A, "outclear");
      read_chk(3'd4, 32'h0, "rd_outset");
      read_chk(3'd5, 32'h0, "rd_outclear");
      read_chk(3'd0, 32'h3A, "rd_data");

      // Blink bit 0 with half-period 4
      bus_wr(1'b1, 3'd0, 32'hFF);
      bus_wr(1'b1, 3'd1, 32'h01);
      bus_wr(1'b1, 3'd2, 32'd4);
      address = 3'd3;
      for (int d = 0; d <= 6; d++) begin
         expect_v(d, 0, ((d / 4) % 2 == 1) ? 32'hFE : 32'hFF, "blink4_out");
         if (d >= 1) expect_v(d, 1, {31'd0, ((d - 1) / 4) % 2 == 1}, "blink4_status");
      end
      repeat (6) tick();

      // Rewrite divider while phase=1
      bus_wr(1'b1, 3'd2, 32'd3);
      expect_v(0, 1, 32'd4, "rd_div_old");
      address = 3'd3;
      for (int d = 0; d <= 4; d++) begin
         expect_v(d, 0, (d >= 3) ? 32'hFE : 32'hFF, "blink3_out");
         if (d >= 1) expect_v(d, 1, (d == 4) ? 32'd1 : 32'd0, "blink3_status");
      end
      repeat (4) tick();

      // Stop blinking
      bus_wr(1'b1, 3'd2, 32'd0);
      expect_v(0, 1, 32'd3, "rd_div_3");
      address = 3'd3;
      for (int d = 0; d <= 3; d++) begin
         expect_v(d, 0, 32'hFF, "stop_out");
         if (d >= 1) expect_v(d, 1, 32'd0, "stop_status");
      end
      repeat (3) tick();

      // Ignored writes
      bus_wr(1'b0, 3'd0, 32'h00);
      expect_v(0, 0, 32'hFF, "cs0_write");
      bus_wr(1'b1, 3'd6, 32'h00);
      expect_v(0, 0, 32'hFF, "addr6_write");
      bus_wr(1'b1, 3'd7, 32'h00);
      expect_v(0, 0, 32'hFF, "addr7_write");
      read_chk(3'd0, 32'hFF, "rd_data_kept");
      read_chk(3'd1, 32'h01, "rd_blinken_kept");
      read_chk(3'd2, 32'h0, "rd_div_kept");
      read_chk(3'd6, 32'h0, "rd_addr6");
      read_chk(3'd7, 32'h0, "rd_addr7");

      // Async reset during blink
      bus_wr(1'b1, 3'd2, 32'd2);
      address = 3'd0;
      expect_v(0, 0, 32'hFF, "pre_rst_out0");
      expect_v(1, 0, 32'hFF, "pre_rst_out1");
      expect_v(2, 0, 32'hFE, "pre_rst_out2");
      expect_v(1, 1, 32'hFF, "pre_rst_rd");
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      expect_v(0, 0, 32'hA5, "async_rst_out");
      expect_v(0, 1, 32'h0, "async_rst_rd");
      tick();
      reset_n = 1'b1;
      tick();
      expect_v(0, 0, 32'hA5, "post_rst_out");
      expect_v(0, 1, 32'hA5, "post_rst_rd_data");
      read_chk(3'd1, 32'h0, "post_rst_blinken");
      read_chk(3'd2, 32'h0, "post_rst_div");
      read_chk(3'd3, 32'h0, "post_rst_status");

      repeat (3) tick();
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
